// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_unit: one-request load/store front-end for the data memory;    |
// | optional misaligned-access trapping via MAU_MISALIGN_CHECK_EN. Rev 1.0    |
// +--------------------------------------------------------------------------+
`ifndef LDB
`define LDB 3'b001
`define LDH 3'b010
`define LDW 3'b011
`define STB 3'b101
`define STH 3'b110
`define STW 3'b111
`endif

module mem_access_unit #(
  parameter logic [31:0] ADDR_LIMIT = 32'h400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_num,
  output logic [3:0]  mem_ctl,
  input  logic [31:0] mem_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  state_t state, state_next;

  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        err_q;

  logic [1:0]  size_m1;
  logic [32:0] end_addr;
  logic        funct3_bad, range_bad, align_bad, req_err;
  logic [2:0]  ctl_code;
  logic [31:0] load_ext;

  always_comb begin
    size_m1 = 2'd0;
    case (req_funct3[1:0])
      2'b01:   size_m1 = 2'd1;
      2'b10:   size_m1 = 2'd3;
      default: size_m1 = 2'd0;
    endcase
  end

  assign funct3_bad = req_we ? (req_funct3 >= 3'b011)
                             : (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
  // 33-bit end address so an access near 2^32 cannot wrap back into range
  assign end_addr  = {1'b0, req_addr} + {31'd0, size_m1};
  assign range_bad = end_addr >= {1'b0, ADDR_LIMIT};
`ifdef MAU_MISALIGN_CHECK_EN
  assign align_bad = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign align_bad = 1'b0;
`endif
  assign req_err = funct3_bad || range_bad || align_bad;

  always_comb begin
    ctl_code = we_q ? `STW : `LDW;
    case (funct3_q[1:0])
      2'b00:   ctl_code = we_q ? `STB : `LDB;
      2'b01:   ctl_code = we_q ? `STH : `LDH;
      default: ctl_code = we_q ? `STW : `LDW;
    endcase
  end

  always_comb begin
    load_ext = mem_out;
    case (funct3_q)
      3'b000:  load_ext = {{24{mem_out[7]}}, mem_out[7:0]};
      3'b001:  load_ext = {{16{mem_out[15]}}, mem_out[15:0]};
      3'b100:  load_ext = {24'd0, mem_out[7:0]};
      3'b101:  load_ext = {16'd0, mem_out[15:0]};
      default: load_ext = mem_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_ctl    = 4'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_ctl    = {1'b1, ctl_code};
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // No memory write may slip through while reset is asserted
    if (rst) mem_ctl = 4'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q     <= req_we;
          funct3_q <= req_funct3;
          addr_q   <= req_addr;
          wdata_q  <= req_wdata;
          err_q    <= req_err;
          rdata_q  <= 32'd0;
        end
        ACCESS: rdata_q <= we_q ? 32'd0 : load_ext;
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_num   = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// Directed bench for mem_access_unit with a byte-array memory model and a
// response scoreboard; honours MAU_MISALIGN_CHECK_EN like the design.
`ifndef LDB
`define LDB 3'b001
`define LDH 3'b010
`define LDW 3'b011
`define STB 3'b101
`define STH 3'b110
`define STW 3'b111
`endif

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata, mem_addr, mem_num, mem_out;
  logic [3:0]  mem_ctl;

  mem_access_unit #(.ADDR_LIMIT(32'h400)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_num(mem_num),
    .mem_ctl(mem_ctl), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic [7:0]  mem [0:2047] = '{default: 8'h00};
  logic [10:0] ma;
  assign ma = mem_addr[10:0];

  always_comb begin
    mem_out = 32'd0;
    if (mem_ctl[3]) begin
      case (mem_ctl[2:0])
        `LDB: mem_out = {24'd0, mem[ma]};
        `LDH: mem_out = {16'd0, mem[ma + 11'd1], mem[ma]};
        `LDW: mem_out = {mem[ma + 11'd3], mem[ma + 11'd2], mem[ma + 11'd1], mem[ma]};
        default: mem_out = 32'd0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (mem_ctl[3]) begin
      case (mem_ctl[2:0])
        `STB: mem[ma] <= mem_num[7:0];
        `STH: begin mem[ma] <= mem_num[7:0]; mem[ma + 11'd1] <= mem_num[15:8]; end
        `STW: begin
          mem[ma] <= mem_num[7:0];          mem[ma + 11'd1] <= mem_num[15:8];
          mem[ma + 11'd2] <= mem_num[23:16]; mem[ma + 11'd3] <= mem_num[31:24];
        end
        default: ;
      endcase
    end
  end

  int          pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
  int          ctl_cycles = 0;
  logic [3:0]  last_ctl = 4'd0;
  logic [32:0] sb [$];
  string       step = "init";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s/%s: observed 0x%08h expected 0x%08h", step, tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_ctl(input logic we, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return {1'b1, we ? `STB : `LDB};
      2'b01:   return {1'b1, we ? `STH : `LDH};
      default: return {1'b1, we ? `STW : `LDW};
    endcase
  endfunction

  // Response monitor: counts enabled memory cycles and drains the scoreboard
  always @(negedge clk) begin
    logic [32:0] e;
    if (mem_ctl[3]) begin
      ctl_cycles++;
      last_ctl = mem_ctl;
    end
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
      else begin
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e[32:1]);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e[0]});
      end
    end
  end

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int hold);
    int c0, lat;
    sb.push_back({exp_rdata, exp_err});
    c0 = ctl_cycles;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1; rsp_ready = (hold == 0);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_err ? 32'd1 : 32'd2);
    if (hold > 0) begin
      repeat (hold) begin
        check("hold_valid", {31'd0, rsp_valid}, 32'd1);
        check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        check("hold_rdata", rsp_rdata, exp_rdata);
        @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("back_idle", {31'd0, req_ready}, 32'd1);
    check("access_cycles", ctl_cycles - c0, exp_err ? 32'd0 : 32'd1);
    if (!exp_err) check("mem_ctl_code", {28'd0, last_ctl}, {28'd0, exp_ctl(we, f3)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    step = "reset";
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = SW; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
    #1 check("ctl_in_rst0", {28'd0, mem_ctl}, 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("ctl_in_rst", {28'd0, mem_ctl}, 32'd0);
      check("ready_in_rst", {31'd0, req_ready}, 32'd1);
      check("valid_in_rst", {31'd0, rsp_valid}, 32'd0);
    end
    check("rdata_rst", rsp_rdata, 32'd0);
    check("err_rst", {31'd0, rsp_err}, 32'd0);
    check("maddr_rst", mem_addr, 32'd0);
    check("mnum_rst", mem_num, 32'd0);
    req_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    check("no_store_in_rst", ctl_cycles, 32'd0);
    do_req(1'b0, LW, 32'h10, 32'd0, 32'd0, 1'b0, 0);

    step = "word";
    do_req(1'b1, SW, 32'h3C, 32'h0000000B, 32'd0, 1'b0, 0);
    do_req(1'b0, LW, 32'h3C, 32'd0, 32'h0000000B, 1'b0, 0);

    step = "byte_half";
    do_req(1'b1, SB,  32'h44, 32'hABCDEFF9, 32'd0, 1'b0, 0);
    do_req(1'b0, LB,  32'h44, 32'd0, 32'hFFFFFFF9, 1'b0, 0);
    do_req(1'b0, LBU, 32'h44, 32'd0, 32'h000000F9, 1'b0, 0);
    do_req(1'b1, SH,  32'h48, 32'h12348001, 32'd0, 1'b0, 0);
    do_req(1'b0, LH,  32'h48, 32'd0, 32'hFFFF8001, 1'b0, 0);
    do_req(1'b0, LHU, 32'h48, 32'd0, 32'h00008001, 1'b0, 0);
    do_req(1'b0, LW,  32'h48, 32'd0, 32'h00008001, 1'b0, 0);

    step = "range_funct3";
    do_req(1'b0, LW, 32'h3FE, 32'd0, 32'd0, 1'b1, 0);
    do_req(1'b1, SW, 32'h3FC, 32'hCAFEF00D, 32'd0, 1'b0, 0);
    do_req(1'b0, LW, 32'h3FC, 32'd0, 32'hCAFEF00D, 1'b0, 0);
    do_req(1'b0, LB, 32'h3FF, 32'd0, 32'hFFFFFFCA, 1'b0, 0);
    do_req(1'b0, LB, 32'h400, 32'd0, 32'd0, 1'b1, 0);
    do_req(1'b0, LH, 32'h3FF, 32'd0, 32'd0, 1'b1, 0);
    do_req(1'b0, LW, 32'hFFFFFFFC, 32'd0, 32'd0, 1'b1, 0);
    do_req(1'b0, 3'b111, 32'h40, 32'd0, 32'd0, 1'b1, 0);
    do_req(1'b0, 3'b110, 32'h40, 32'd0, 32'd0, 1'b1, 0);
    do_req(1'b1, 3'b011, 32'h40, 32'h55555555, 32'd0, 1'b1, 0);

    step = "misalign";
    do_req(1'b1, SW, 32'h40, 32'h11223344, 32'd0, 1'b0, 0);
`ifdef MAU_MISALIGN_CHECK_EN
    do_req(1'b0, LW, 32'h41, 32'd0, 32'd0, 1'b1, 0);
    do_req(1'b0, LH, 32'h43, 32'd0, 32'd0, 1'b1, 0);
`else
    do_req(1'b0, LW, 32'h41, 32'd0, 32'hF9112233, 1'b0, 0);
    do_req(1'b0, LH, 32'h43, 32'd0, 32'hFFFFF911, 1'b0, 0);
`endif

    step = "hold";
    do_req(1'b0, LW, 32'h3C, 32'd0, 32'h0000000B, 1'b0, 5);

    step = "rst_mid_access";
    req_we = 1'b1; req_funct3 = SW; req_addr = 32'h80; req_wdata = 32'h12345678;
    req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    c0 = ctl_cycles;
    rst = 1'b1;
    #1 check("ctl_gated", {28'd0, mem_ctl}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);
    repeat (3) begin
      check("no_rsp_after_rst", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    check("no_access_after_rst", ctl_cycles - c0, 32'd0);
    do_req(1'b0, LW, 32'h80, 32'd0, 32'd0, 1'b0, 0);
    check("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
